// File: rtl/ct_f_spsram_pkg.sv
// Shared types and slice geometry for the 256x196 SRAM request controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package ct_f_spsram_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 196;
  localparam int NUM_SLICES = 5;

  // Index k matches req_slice_en[k]; slice 4 is the narrow 4-bit top slice.
  localparam int SLICE_HI [NUM_SLICES-1:0] = '{195, 191, 143, 95, 47};
  localparam int SLICE_LO [NUM_SLICES-1:0] = '{192, 144, 96, 48, 0};

  typedef struct packed {
    logic                  wr;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [NUM_SLICES-1:0] slice_en;
  } req_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Active-low per-bit write enable: a bit is written when its slice is enabled.
  function automatic logic [DATA_W-1:0] expand_wen(input logic [NUM_SLICES-1:0] slice_en);
    logic [DATA_W-1:0] wen;
    wen = '1;
    for (int b = 0; b < DATA_W; b++) begin
      for (int k = 0; k < NUM_SLICES; k++) begin
        if (b >= SLICE_LO[k] && b <= SLICE_HI[k]) begin
          wen[b] = ~slice_en[k];
        end
      end
    end
    return wen;
  endfunction

endpackage

// File: rtl/ct_f_spsram_rsp_fifo.sv
// Two-entry response buffer holding SRAM read data until the consumer takes it.
// Latency: data pushed in cycle N is visible at the head in cycle N+1.
// Backpressure: pop is ignored when empty; the caller guarantees no push when full.
module ct_f_spsram_rsp_fifo #(
  parameter int WIDTH = 196
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             vld_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             pop_eff;

  assign pop_eff     = pop_i & (count_q != 2'd0);
  assign head_data_o = mem_q[rd_ptr_q];
  assign vld_o       = (count_q != 2'd0);
  assign count_o     = count_q;

  // Storage, pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_q ^ push_i;
      rd_ptr_q <= rd_ptr_q ^ pop_eff;
      count_q  <= count_q + 2'(push_i) - 2'(pop_eff);
    end
  end

endmodule

// File: rtl/ct_f_spsram_256x196_ctrl.sv
// Request controller driving a 256x196 single-port SRAM wrapper, with post-reset clear sweep.
// Latency: SRAM pins combinational from the accepted request; read data on rsp_* 2 cycles later.
// Backpressure: reads stall when buffered plus in-flight reads reach 2; writes never stall.
module ct_f_spsram_256x196_ctrl
  import ct_f_spsram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 196,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA  = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_SLICES-1:0] req_slice_en,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [1:0]            buf_count;
  logic                  run;
  logic                  accept;
  req_t                  req;

  assign req       = {req_wr, req_addr, req_wdata, req_slice_en};
  assign run       = (state_q == ST_RUN) & ~RST;
  assign init_done = (state_q == ST_RUN);
  // Reads reserve a buffer slot at issue so the unconditional capture next cycle always fits.
  assign req_rdy   = run & (req.wr | (({1'b0, buf_count} + {2'b00, rd_inflight_q}) < 3'd2));
  assign accept    = req_vld & req_rdy;

  // Next-state: sweep one address per cycle in INIT, then stay in RUN until reset.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_inflight_d = accept & ~req.wr;
    case (state_q)
      ST_INIT: begin
        if (!INIT_EN) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, sweep counter and read-in-flight flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  // SRAM pin drive: sweep writes in INIT, pass-through of the accepted request in RUN.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (!RST) begin
      if (state_q == ST_INIT) begin
        if (INIT_EN) begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
          sram_a    = cnt_q;
          sram_d    = INIT_DATA;
        end
      end else begin
        sram_a = req.addr;
        sram_d = req.wdata;
        if (accept) begin
          sram_cen = 1'b0;
          if (req.wr) begin
            // An all-zero slice mask still consumes the slot but leaves the array untouched.
            sram_gwen = ~|req.slice_en;
            sram_wen  = expand_wen(req.slice_en);
          end
        end
      end
    end
  end

  ct_f_spsram_rsp_fifo #(
    .WIDTH(DATA_WIDTH)
  ) u_rsp_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (rd_inflight_q),
    .push_data_i (sram_q),
    .pop_i       (rsp_rdy),
    .head_data_o (rsp_data),
    .vld_o       (rsp_vld),
    .count_o     (buf_count)
  );

endmodule

// File: tb/tb_ct_f_spsram_256x196_ctrl.sv
// Bench for the SRAM request controller: behavioural SRAM, reference memory and response queue.
// Latency: checks pin timing, 2-cycle read return and 256-cycle clear sweep.
// Backpressure: random and directed rsp_rdy stalls against the 2-deep read window.
module tb_ct_f_spsram_256x196_ctrl;

  localparam int AW = 8;
  localparam int DW = 196;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [4:0]    req_slice_en = '0;
  logic          rsp_vld;
  logic          rsp_rdy = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          init_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  ct_f_spsram_256x196_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .INIT_EN    (1'b1),
    .INIT_DATA  ('0)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_slice_en (req_slice_en),
    .rsp_vld      (rsp_vld),
    .rsp_rdy      (rsp_rdy),
    .rsp_data     (rsp_data),
    .init_done    (init_done),
    .sram_a       (sram_a),
    .sram_cen     (sram_cen),
    .sram_gwen    (sram_gwen),
    .sram_wen     (sram_wen),
    .sram_d       (sram_d),
    .sram_q       (sram_q)
  );

  always #5 CLK = ~CLK;

  int            checks = 0;
  int            errors = 0;
  bit            acc;
  int            npop = 0;
  int            scr_idx = 0;
  logic [DW-1:0] sram_mem [256];
  logic [DW-1:0] ref_mem  [256];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rsp;

  function automatic logic [DW-1:0] rand_data();
    logic [223:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Wrapper model: masked write or registered read on enabled cycles; junk-filled while in reset.
  always @(posedge CLK) begin
    if (RST && scr_idx < 256) begin
      sram_mem[scr_idx[7:0]] <= rand_data();
      scr_idx <= scr_idx + 1;
    end else if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= sram_mem[sram_a];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // Slice k covers 48 bits starting at 48*k, except the top 4 bits which belong to slice 4.
  function automatic logic [DW-1:0] wen_of(input logic [4:0] se);
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = ~se[(i >= 192) ? 4 : i / 48];
    return w;
  endfunction

  // One clock: observe the settled cycle, update the model, advance to the next negedge.
  task automatic cycle();
    logic [DW-1:0] m;
    #1;
    if (rsp_vld) begin
      if (exp_q.size() == 0) chk("rsp_spurious", DW'(rsp_vld), '0);
      else begin
        chk("rsp_data", rsp_data, exp_q[0]);
        if (rsp_rdy) begin
          last_rsp = rsp_data;
          void'(exp_q.pop_front());
          npop++;
        end
      end
    end
    acc = req_vld && req_rdy;
    if (acc) begin
      chk("iss_cen", DW'(sram_cen), '0);
      chk("iss_a", DW'(sram_a), DW'(req_addr));
      if (req_wr) begin
        m = ~wen_of(req_slice_en);
        chk("wr_wen", sram_wen, ~m);
        chk("wr_gwen", DW'(sram_gwen), DW'(req_slice_en == 5'd0));
        chk("wr_d", sram_d, req_wdata);
        ref_mem[req_addr] = (ref_mem[req_addr] & ~m) | (req_wdata & m);
      end else begin
        chk("rd_gwen", DW'(sram_gwen), DW'(1));
        chk("rd_wen", sram_wen, '1);
        exp_q.push_back(ref_mem[req_addr]);
        chk("no_ovf", DW'(exp_q.size() <= 2), DW'(1));
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [4:0] se);
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_slice_en = se;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (acc) break;
    end
    chk("req_accept", DW'(acc), DW'(1));
    req_vld = 1'b0;
  endtask

  task automatic read_lat(input logic [AW-1:0] a);
    rsp_rdy = 1'b1;
    do_req(1'b0, a, '0, '0);
    #1 chk("lat_vld_t1", DW'(rsp_vld), '0);
    cycle();
    #1 chk("lat_vld_t2", DW'(rsp_vld), DW'(1));
    cycle();
  endtask

  task automatic drain();
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    chk("drain_empty", DW'(exp_q.size()), '0);
  endtask

  task automatic sweep_check(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      #1;
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 || sram_a !== 8'(i) ||
          sram_d !== '0 || req_rdy !== 1'b0 || init_done !== 1'b0) bad++;
      @(negedge CLK);
    end
    chk(tag, DW'(bad), '0);
    #1 chk("done_after_sweep", DW'(init_done), DW'(1));
    chk("idle_cen", DW'(sram_cen), DW'(1));
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    @(negedge CLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] part_exp;
    int            n0;
    int            edges;

    // Reset values, held long enough for the wrapper model to fill with junk.
    repeat (260) @(negedge CLK);
    #1;
    chk("rst_req_rdy", DW'(req_rdy), '0);
    chk("rst_rsp_vld", DW'(rsp_vld), '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_init_done", DW'(init_done), '0);
    chk("rst_cen", DW'(sram_cen), DW'(1));
    chk("rst_gwen", DW'(sram_gwen), DW'(1));
    chk("rst_wen", sram_wen, '1);
    @(negedge CLK);

    // Clear sweep, then the cleared array reads back zero.
    RST = 1'b0;
    sweep_check("sweep");
    read_lat(8'hA5);
    chk("a5_zero", last_rsp, '0);

    // Full write then read; an empty-mask write must not disturb it.
    do_req(1'b1, 8'h10, '1, 5'b11111);
    read_lat(8'h10);
    chk("full_data", last_rsp, '1);
    do_req(1'b1, 8'h10, '0, 5'b00000);
    read_lat(8'h10);
    chk("nomask_data", last_rsp, '1);

    // Partial slice write.
    do_req(1'b1, 8'h20, '0, 5'b11111);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 8'h20; req_wdata = '1; req_slice_en = 5'b00101;
    #1;
    chk("part_wen_s2", DW'(sram_wen[143:96]), '0);
    chk("part_wen_hi", DW'(sram_wen[195:144]), DW'({52{1'b1}}));
    cycle();
    chk("part_acc", DW'(acc), DW'(1));
    req_vld = 1'b0;
    read_lat(8'h20);
    part_exp = '0;
    part_exp[143:96] = '1;
    part_exp[47:0] = '1;
    chk("part_data", last_rsp, part_exp);

    // Backpressure: two reads fill the window, third waits, writes still pass.
    for (int a = 1; a <= 3; a++) do_req(1'b1, 8'(a), rand_data(), 5'b11111);
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h01;
    cycle();
    chk("bp_acc1", DW'(acc), DW'(1));
    req_addr = 8'h02;
    cycle();
    chk("bp_acc2", DW'(acc), DW'(1));
    req_addr = 8'h03;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_blocked", DW'(acc), '0);
    end
    req_wr = 1'b1; req_addr = 8'h30; req_wdata = rand_data(); req_slice_en = 5'b11111;
    cycle();
    chk("bp_wr_acc", DW'(acc), DW'(1));
    req_wr = 1'b0; req_addr = 8'h03;
    rsp_rdy = 1'b1;
    n0 = npop;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (acc) break;
    end
    chk("bp_rd3_acc", DW'(acc), DW'(1));
    chk("bp_pops_before", DW'(npop - n0), DW'(2));
    drain();

    // Randomized traffic over a small address set to force read-after-write hits.
    for (int n = 0; n < 2000; n++) begin
      req_vld      = 1'($urandom_range(0, 1));
      req_wr       = 1'($urandom_range(0, 1));
      req_addr     = 8'($urandom_range(0, 15));
      req_wdata    = rand_data();
      req_slice_en = 5'($urandom);
      rsp_rdy      = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    // Reset from RUN with a buffered response, then reset again mid-sweep.
    rsp_rdy = 1'b0;
    do_req(1'b0, 8'h05, '0, '0);
    cycle();
    #1 chk("pre_rst_vld", DW'(rsp_vld), DW'(1));
    RST = 1'b1;
    @(negedge CLK);
    exp_q.delete();
    #1;
    chk("rst1_vld", DW'(rsp_vld), '0);
    chk("rst1_done", DW'(init_done), '0);
    RST = 1'b0;
    @(negedge CLK);
    repeat (99) @(negedge CLK);
    #1 chk("mid_addr", DW'(sram_a), DW'(100));
    RST = 1'b1;
    @(negedge CLK);
    #1;
    chk("mid_rst_vld", DW'(rsp_vld), '0);
    chk("mid_rst_cen", DW'(sram_cen), DW'(1));
    RST = 1'b0;
    #1 chk("restart_addr", DW'(sram_a), '0);
    edges = 0;
    while (!init_done && edges < 300) begin
      @(posedge CLK);
      #1;
      edges++;
    end
    chk("done_latency", DW'(edges), DW'(256));
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    @(negedge CLK);
    read_lat(8'h05);
    chk("post_sweep_zero", last_rsp, '0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
